u_pctrlu: RTL and testbench
===========================

Name: u_pctrlu

Overview:
Pipelined control unit and the successor to the combinational decoder. It decodes the ID-stage instruction and carries the control bundle through parametrised EX/MEM/WB stage registers. It adds stall/flush handling and a multi-cycle multiplier interlock that holds the multiply in EX for MULT_LAT cycles. It sits between the IF/ID register and the datapath stage muxes, and drives the PC/IF/ID hold.

Parameters:
MULT_LAT, 4, cycles a multiply occupies EX (legal 1..16)
MEM_STAGES, 1, number of MEM register stages between EX and WB (legal 1..4)
ALU_CTR_W, 4, ALU control width

Ports:
i_u_pctrlu_clk  in  1  clock
i_u_pctrlu_rst_n  in  1  asynchronous active-low reset
i_u_pctrlu_op  in  6  ID opcode
i_u_pctrlu_funct  in  6  ID funct
i_u_pctrlu_valid  in  1  ID holds a real instruction
i_u_pctrlu_hazard_stall  in  1  load-use stall from hazard unit
i_u_pctrlu_flush_id  in  1  kill ID instruction (taken branch/jump)
o_u_pctrlu_stall  out  1  hold PC and IF/ID
o_u_pctrlu_id_pc_src / _id_ext_op  out  1 each  ID-stage controls
o_u_pctrlu_id_jmp / _id_branch  out  2 each  ID-stage controls
o_u_pctrlu_ex_valid, _ex_alu_src, _ex_mult_en, _ex_data_sel  out  1 each
o_u_pctrlu_ex_alu_ctr  out  ALU_CTR_W
o_u_pctrlu_ex_reg_dst, _ex_mf  out  2 each
o_u_pctrlu_mem_valid, _mem_wr, _mem_word  out  1 each  (first MEM stage)
o_u_pctrlu_wb_valid, _wb_reg_wr, _wb_mem_to_reg  out  1 each
o_u_pctrlu_mult_busy  out  1  multiply held in EX
o_u_pctrlu_mult_done  out  1  one-cycle pulse, last EX cycle of a multiply

Behaviour:
- Reset, asynchronous: all stage valids and all registered controls go to 0, the counter goes to 0, and the FSM goes to IDLE. Reset during a multiply aborts it immediately.
- ID decode is combinational via the existing u_ctrlu.
- ID outputs are forced to 0 when valid=0 or o_stall=1. This gating prevents a double PC redirect while stalled.
- mult_hold = ex_valid & ex_mult_en & (cnt != 0).
- o_stall = hazard_stall | mult_hold.
- EX register update, per edge, highest priority first:
  - mult_hold: EX keeps its contents.
  - hazard_stall, flush_id, or !valid: EX takes a bubble (valid=0, all controls 0).
  - Otherwise EX takes the decoded bundle.
- MEM[0] takes a bubble while mult_hold; otherwise it takes the EX mem/wb fields.
- MEM[k] takes MEM[k-1]. WB takes MEM[MEM_STAGES-1].
- Latency: an unstalled instruction appears in EX 1 cycle after ID, in MEM at +2, and in WB at +2+MEM_STAGES.
- Non-valid stages have all of their control outputs at 0.
- Multiplier FSM:
  - IDLE: no multiply in EX.
  - BUSY: cnt != 0.
  - LAST: cnt == 0 with a multiply in EX.
  - When a multiply is loaded into EX, cnt is loaded with MULT_LAT-1. The FSM goes to BUSY, or to LAST if MULT_LAT=1.
  - cnt decrements once per cycle while in BUSY; BUSY moves to LAST when cnt reaches 0.
  - LAST asserts mult_done. On the next edge the multiply leaves EX and the FSM goes to IDLE, or back to BUSY if another multiply enters EX on that edge.
- mult_busy = 1 in BUSY only.
- Back-to-back multiplies each take a full MULT_LAT cycles.
- flush_id during mult_hold is ignored because ID holds; the source must re-assert it after the stall.
- hazard_stall during mult_hold: EX still holds, and o_stall stays 1.
- mfhi/mflo need no extra interlock. HI/LO are written on the LAST edge, and the mf instruction reaches EX only after that edge.

Decomposition:
- Package u_pctrlu_pkg holds:
  - the packed structs ex_ctrl_t, mem_ctrl_t and wb_ctrl_t;
  - the BUBBLE constants;
  - the enum mult_st_e {IDLE, BUSY, LAST};
  - the opcode/funct localparams used by the bench.
- Natural sub-module: b_multseq, containing the counter, the FSM, and the busy/done/hold outputs.
- Stage registers are a generate loop over MEM_STAGES.

Test Plan:
- Reset asserted mid-stream → every output is 0 and the FSM is IDLE. After release, an ADD (op 0x00, funct 0x20) reaches EX at +1 and WB at +3 with wb_reg_wr=1 (MEM_STAGES=1).
- LW (op 0x23) then SW (op 0x2B), unstalled → SW shows mem_wr=1 at MEM one cycle after LW shows mem_to_reg path. LW reaches WB with mem_to_reg=1 and reg_wr=1.
- MULT (op 0x00, funct 0x18), MULT_LAT=4, followed by ADD → stall=1 for 3 cycles; mult_busy=1 for 3 cycles; mult_done pulses in cycle 4; MEM receives 3 bubbles; ADD enters EX on the cycle after done.
- MULT immediately followed by MFHI (funct 0x10), MULT_LAT=4 → MFHI enters EX exactly 4 cycles after MULT with ex_mf nonzero and no extra stall.
- BEQ in ID with hazard_stall=1 for 2 cycles → id_branch=0 and pc_src=0 while stalled. EX receives 2 bubbles; BEQ controls appear once the stall drops.
- MULT_LAT=1 and MEM_STAGES=3 sweep → a MULT produces no stall and mult_done pulses in its single EX cycle; ADD reaches WB at +5.

Source files
------------

// File: rtl/u_pctrlu_pkg.sv
// Shared types for the pipelined control unit: stage control bundles,
// bubble constants, multiplier FSM states, opcode/funct encodings and
// the ID-stage decoder.
package u_pctrlu_pkg;

  localparam int unsigned ALU_W = 4;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes
  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_JALR  = 6'h09;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_SLTU  = 6'h2B;

  // ALU control codes
  localparam logic [ALU_W-1:0] ALU_AND  = 4'h0;
  localparam logic [ALU_W-1:0] ALU_OR   = 4'h1;
  localparam logic [ALU_W-1:0] ALU_ADD  = 4'h2;
  localparam logic [ALU_W-1:0] ALU_XOR  = 4'h3;
  localparam logic [ALU_W-1:0] ALU_SUB  = 4'h6;
  localparam logic [ALU_W-1:0] ALU_SLT  = 4'h7;
  localparam logic [ALU_W-1:0] ALU_SLTU = 4'h8;
  localparam logic [ALU_W-1:0] ALU_SLL  = 4'h9;
  localparam logic [ALU_W-1:0] ALU_SRL  = 4'hA;
  localparam logic [ALU_W-1:0] ALU_SRA  = 4'hB;
  localparam logic [ALU_W-1:0] ALU_NOR  = 4'hC;
  localparam logic [ALU_W-1:0] ALU_LUI  = 4'hD;

  // Two-bit selector encodings (0 means none / rt)
  localparam logic [1:0] RD_RT    = 2'd0;
  localparam logic [1:0] RD_RD    = 2'd1;
  localparam logic [1:0] RD_RA    = 2'd2;
  localparam logic [1:0] MF_HI    = 2'd1;
  localparam logic [1:0] MF_LO    = 2'd2;
  localparam logic [1:0] JMP_IMM  = 2'd1;
  localparam logic [1:0] JMP_REG  = 2'd2;
  localparam logic [1:0] BR_EQ    = 2'd1;
  localparam logic [1:0] BR_NE    = 2'd2;

  typedef struct packed {
    logic       pc_src;
    logic       ext_op;
    logic [1:0] jmp;
    logic [1:0] branch;
  } id_ctrl_t;

  typedef struct packed {
    logic valid;
    logic reg_wr;
    logic mem_to_reg;
  } wb_ctrl_t;

  typedef struct packed {
    logic valid;
    logic mem_wr;
    logic mem_word;
    logic reg_wr;
    logic mem_to_reg;
  } mem_ctrl_t;

  typedef struct packed {
    logic             valid;
    logic             alu_src;
    logic             mult_en;
    logic             data_sel;
    logic [ALU_W-1:0] alu_ctr;
    logic [1:0]       reg_dst;
    logic [1:0]       mf;
    logic             mem_wr;
    logic             mem_word;
    logic             reg_wr;
    logic             mem_to_reg;
  } ex_ctrl_t;

  typedef struct packed {
    id_ctrl_t id;
    ex_ctrl_t ex;
  } dec_t;

  localparam ex_ctrl_t  EX_BUBBLE  = '0;
  localparam mem_ctrl_t MEM_BUBBLE = '0;
  localparam wb_ctrl_t  WB_BUBBLE  = '0;

  typedef enum logic [1:0] {IDLE, BUSY, LAST} mult_st_e;

  // ID-stage decoder; unknown encodings decode to a valid no-op
  function automatic dec_t decode(input logic [5:0] op, input logic [5:0] funct);
    dec_t d;
    d = '0;
    d.ex.valid = 1'b1;
    case (op)
      OP_RTYPE: begin
        d.ex.reg_dst = RD_RD;
        d.ex.reg_wr  = 1'b1;
        case (funct)
          FN_SLL:            d.ex.alu_ctr = ALU_SLL;
          FN_SRL:            d.ex.alu_ctr = ALU_SRL;
          FN_SRA:            d.ex.alu_ctr = ALU_SRA;
          FN_ADD, FN_ADDU:   d.ex.alu_ctr = ALU_ADD;
          FN_SUB, FN_SUBU:   d.ex.alu_ctr = ALU_SUB;
          FN_AND:            d.ex.alu_ctr = ALU_AND;
          FN_OR:             d.ex.alu_ctr = ALU_OR;
          FN_XOR:            d.ex.alu_ctr = ALU_XOR;
          FN_NOR:            d.ex.alu_ctr = ALU_NOR;
          FN_SLT:            d.ex.alu_ctr = ALU_SLT;
          FN_SLTU:           d.ex.alu_ctr = ALU_SLTU;
          FN_MFHI:           d.ex.mf      = MF_HI;
          FN_MFLO:           d.ex.mf      = MF_LO;
          FN_JR: begin
            d.ex.reg_wr  = 1'b0;
            d.ex.reg_dst = RD_RT;
            d.id.jmp     = JMP_REG;
            d.id.pc_src  = 1'b1;
          end
          FN_JALR: begin
            d.id.jmp      = JMP_REG;
            d.id.pc_src   = 1'b1;
            d.ex.data_sel = 1'b1;
          end
          FN_MULT, FN_MULTU: begin
            d.ex.mult_en = 1'b1;
            d.ex.reg_wr  = 1'b0;
            d.ex.reg_dst = RD_RT;
          end
          default: begin
            d.ex.reg_wr  = 1'b0;
            d.ex.reg_dst = RD_RT;
          end
        endcase
      end
      OP_J: begin
        d.id.jmp    = JMP_IMM;
        d.id.pc_src = 1'b1;
      end
      OP_JAL: begin
        d.id.jmp      = JMP_IMM;
        d.id.pc_src   = 1'b1;
        d.ex.reg_wr   = 1'b1;
        d.ex.reg_dst  = RD_RA;
        d.ex.data_sel = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        d.id.branch  = (op == OP_BEQ) ? BR_EQ : BR_NE;
        d.id.pc_src  = 1'b1;
        d.id.ext_op  = 1'b1;
        d.ex.alu_ctr = ALU_SUB;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: begin
        d.id.ext_op  = 1'b1;
        d.ex.alu_src = 1'b1;
        d.ex.reg_wr  = 1'b1;
        d.ex.alu_ctr = (op == OP_SLTI)  ? ALU_SLT :
                       (op == OP_SLTIU) ? ALU_SLTU : ALU_ADD;
      end
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        d.ex.alu_src = 1'b1;
        d.ex.reg_wr  = 1'b1;
        d.ex.alu_ctr = (op == OP_ANDI) ? ALU_AND :
                       (op == OP_ORI)  ? ALU_OR  :
                       (op == OP_XORI) ? ALU_XOR : ALU_LUI;
      end
      OP_LB, OP_LW: begin
        d.id.ext_op     = 1'b1;
        d.ex.alu_src    = 1'b1;
        d.ex.alu_ctr    = ALU_ADD;
        d.ex.reg_wr     = 1'b1;
        d.ex.mem_to_reg = 1'b1;
        d.ex.mem_word   = (op == OP_LW);
      end
      OP_SB, OP_SW: begin
        d.id.ext_op   = 1'b1;
        d.ex.alu_src  = 1'b1;
        d.ex.alu_ctr  = ALU_ADD;
        d.ex.mem_wr   = 1'b1;
        d.ex.mem_word = (op == OP_SW);
      end
      default: ;
    endcase
    return d;
  endfunction

  function automatic mem_ctrl_t ex2mem(input ex_ctrl_t e);
    mem_ctrl_t m;
    m.valid      = e.valid;
    m.mem_wr     = e.mem_wr;
    m.mem_word   = e.mem_word;
    m.reg_wr     = e.reg_wr;
    m.mem_to_reg = e.mem_to_reg;
    return m;
  endfunction

  function automatic wb_ctrl_t mem2wb(input mem_ctrl_t m);
    wb_ctrl_t w;
    w.valid      = m.valid;
    w.reg_wr     = m.reg_wr;
    w.mem_to_reg = m.mem_to_reg;
    return w;
  endfunction

endpackage

// File: rtl/u_pctrlu_multseq.sv
// Multi-cycle multiply sequencer: counts a multiply's residency in EX.
// Ports: clk/rst_n; i_load (multiply enters EX this edge); i_ex_mult
// (EX holds a valid multiply); o_hold_c (keep EX, combinational);
// o_busy (BUSY state); o_done (LAST state, final EX cycle).
module b_multseq
  import u_pctrlu_pkg::*;
#(
  parameter int unsigned MULT_LAT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_load,
  input  logic i_ex_mult,
  output logic o_hold_c,
  output logic o_busy,
  output logic o_done
);

  localparam int unsigned CNT_W = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MULT_LAT - 1);

  mult_st_e         state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next state; a new multiply can only load from IDLE or LAST since
  // BUSY holds EX
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: ;
      BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = LAST;
      end
      LAST:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (i_load) begin
      cnt_d   = CNT_INIT;
      state_d = (MULT_LAT == 1) ? LAST : BUSY;
    end
    busy_d = (state_d == BUSY);
    done_d = (state_d == LAST);
  end

  assign o_hold_c = i_ex_mult & (cnt_q != '0);
  assign o_busy   = busy_q;
  assign o_done   = done_q;

endmodule

// File: rtl/u_pctrlu.sv
// Pipelined control unit: decodes the ID instruction, carries its control
// bundle through EX, MEM_STAGES MEM registers and WB, and interlocks on
// load-use stalls and multi-cycle multiplies.
// Ports: clk/rst_n; ID op/funct/valid; hazard_stall and flush_id from the
// hazard unit; o_stall holds PC and IF/ID; o_id_* ID-stage controls
// (combinational); o_ex_*, o_mem_*, o_wb_* registered stage controls;
// o_mult_busy/o_mult_done multiplier status.
module u_pctrlu
  import u_pctrlu_pkg::*;
#(
  parameter int unsigned MULT_LAT   = 4,
  parameter int unsigned MEM_STAGES = 1,
  parameter int unsigned ALU_CTR_W  = 4
) (
  input  logic                 i_u_pctrlu_clk,
  input  logic                 i_u_pctrlu_rst_n,
  input  logic [5:0]           i_u_pctrlu_op,
  input  logic [5:0]           i_u_pctrlu_funct,
  input  logic                 i_u_pctrlu_valid,
  input  logic                 i_u_pctrlu_hazard_stall,
  input  logic                 i_u_pctrlu_flush_id,
  output logic                 o_u_pctrlu_stall,
  output logic                 o_u_pctrlu_id_pc_src,
  output logic                 o_u_pctrlu_id_ext_op,
  output logic [1:0]           o_u_pctrlu_id_jmp,
  output logic [1:0]           o_u_pctrlu_id_branch,
  output logic                 o_u_pctrlu_ex_valid,
  output logic                 o_u_pctrlu_ex_alu_src,
  output logic                 o_u_pctrlu_ex_mult_en,
  output logic                 o_u_pctrlu_ex_data_sel,
  output logic [ALU_CTR_W-1:0] o_u_pctrlu_ex_alu_ctr,
  output logic [1:0]           o_u_pctrlu_ex_reg_dst,
  output logic [1:0]           o_u_pctrlu_ex_mf,
  output logic                 o_u_pctrlu_mem_valid,
  output logic                 o_u_pctrlu_mem_wr,
  output logic                 o_u_pctrlu_mem_word,
  output logic                 o_u_pctrlu_wb_valid,
  output logic                 o_u_pctrlu_wb_reg_wr,
  output logic                 o_u_pctrlu_wb_mem_to_reg,
  output logic                 o_u_pctrlu_mult_busy,
  output logic                 o_u_pctrlu_mult_done
);

  logic      clk, rst_n;
  dec_t      dec_c;
  id_ctrl_t  id_c;
  logic      mult_hold_c, stall_c, load_c;
  ex_ctrl_t  ex_q, ex_d;
  mem_ctrl_t mem_q [MEM_STAGES];
  mem_ctrl_t mem_d [MEM_STAGES];
  wb_ctrl_t  wb_q, wb_d;

  assign clk   = i_u_pctrlu_clk;
  assign rst_n = i_u_pctrlu_rst_n;

  assign dec_c   = decode(i_u_pctrlu_op, i_u_pctrlu_funct);
  assign stall_c = i_u_pctrlu_hazard_stall | mult_hold_c;

  // ID controls are suppressed while held so a branch redirects only once
  assign id_c = (i_u_pctrlu_valid & ~stall_c) ? dec_c.id : '0;

  // An instruction leaves ID only when nothing holds, stalls or kills it
  assign load_c = ~mult_hold_c & ~i_u_pctrlu_hazard_stall &
                  ~i_u_pctrlu_flush_id & i_u_pctrlu_valid;

  // EX update: hold during multiply, else bubble or decoded bundle
  always_comb begin
    ex_d = EX_BUBBLE;
    if (mult_hold_c) ex_d = ex_q;
    else if (load_c) ex_d = dec_c.ex;
  end

  b_multseq #(
    .MULT_LAT (MULT_LAT)
  ) u_multseq (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (load_c & dec_c.ex.mult_en),
    .i_ex_mult (ex_q.valid & ex_q.mult_en),
    .o_hold_c  (mult_hold_c),
    .o_busy    (o_u_pctrlu_mult_busy),
    .o_done    (o_u_pctrlu_mult_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ex_q <= EX_BUBBLE;
    else        ex_q <= ex_d;
  end

  // MEM stage chain; the first stage sees bubbles while EX is held
  for (genvar k = 0; k < MEM_STAGES; k++) begin : g_mem
    if (k == 0) begin : g_first
      assign mem_d[k] = mult_hold_c ? MEM_BUBBLE : ex2mem(ex_q);
    end else begin : g_next
      assign mem_d[k] = mem_q[k-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) mem_q[k] <= MEM_BUBBLE;
      else        mem_q[k] <= mem_d[k];
    end
  end

  assign wb_d = mem2wb(mem_q[MEM_STAGES-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wb_q <= WB_BUBBLE;
    else        wb_q <= wb_d;
  end

  assign o_u_pctrlu_stall         = stall_c;
  assign o_u_pctrlu_id_pc_src     = id_c.pc_src;
  assign o_u_pctrlu_id_ext_op     = id_c.ext_op;
  assign o_u_pctrlu_id_jmp        = id_c.jmp;
  assign o_u_pctrlu_id_branch     = id_c.branch;
  assign o_u_pctrlu_ex_valid      = ex_q.valid;
  assign o_u_pctrlu_ex_alu_src    = ex_q.alu_src;
  assign o_u_pctrlu_ex_mult_en    = ex_q.mult_en;
  assign o_u_pctrlu_ex_data_sel   = ex_q.data_sel;
  assign o_u_pctrlu_ex_alu_ctr    = ALU_CTR_W'(ex_q.alu_ctr);
  assign o_u_pctrlu_ex_reg_dst    = ex_q.reg_dst;
  assign o_u_pctrlu_ex_mf         = ex_q.mf;
  assign o_u_pctrlu_mem_valid     = mem_q[0].valid;
  assign o_u_pctrlu_mem_wr        = mem_q[0].mem_wr;
  assign o_u_pctrlu_mem_word      = mem_q[0].mem_word;
  assign o_u_pctrlu_wb_valid      = wb_q.valid;
  assign o_u_pctrlu_wb_reg_wr     = wb_q.reg_wr;
  assign o_u_pctrlu_wb_mem_to_reg = wb_q.mem_to_reg;

endmodule

// File: tb/tb_u_pctrlu.sv
// Directed bench for u_pctrlu: instance a (MULT_LAT=4, MEM_STAGES=1) and
// instance b (MULT_LAT=1, MEM_STAGES=3) share clock and stimulus.
module tb_u_pctrlu;
  import u_pctrlu_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] op, funct;
  logic       valid, hz, fl;

  logic       a_stall, a_pc_src, a_ext_op, a_ex_valid, a_alu_src, a_mult_en, a_data_sel;
  logic [1:0] a_jmp, a_branch, a_reg_dst, a_mf;
  logic [3:0] a_alu_ctr;
  logic       a_mem_valid, a_mem_wr, a_mem_word, a_wb_valid, a_wb_reg_wr, a_wb_m2r;
  logic       a_busy, a_done;

  logic       b_stall, b_pc_src, b_ext_op, b_ex_valid, b_alu_src, b_mult_en, b_data_sel;
  logic [1:0] b_jmp, b_branch, b_reg_dst, b_mf;
  logic [3:0] b_alu_ctr;
  logic       b_mem_valid, b_mem_wr, b_mem_word, b_wb_valid, b_wb_reg_wr, b_wb_m2r;
  logic       b_busy, b_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  u_pctrlu #(.MULT_LAT(4), .MEM_STAGES(1), .ALU_CTR_W(4)) u_a (
    .i_u_pctrlu_clk(clk), .i_u_pctrlu_rst_n(rst_n),
    .i_u_pctrlu_op(op), .i_u_pctrlu_funct(funct), .i_u_pctrlu_valid(valid),
    .i_u_pctrlu_hazard_stall(hz), .i_u_pctrlu_flush_id(fl),
    .o_u_pctrlu_stall(a_stall), .o_u_pctrlu_id_pc_src(a_pc_src),
    .o_u_pctrlu_id_ext_op(a_ext_op), .o_u_pctrlu_id_jmp(a_jmp),
    .o_u_pctrlu_id_branch(a_branch), .o_u_pctrlu_ex_valid(a_ex_valid),
    .o_u_pctrlu_ex_alu_src(a_alu_src), .o_u_pctrlu_ex_mult_en(a_mult_en),
    .o_u_pctrlu_ex_data_sel(a_data_sel), .o_u_pctrlu_ex_alu_ctr(a_alu_ctr),
    .o_u_pctrlu_ex_reg_dst(a_reg_dst), .o_u_pctrlu_ex_mf(a_mf),
    .o_u_pctrlu_mem_valid(a_mem_valid), .o_u_pctrlu_mem_wr(a_mem_wr),
    .o_u_pctrlu_mem_word(a_mem_word), .o_u_pctrlu_wb_valid(a_wb_valid),
    .o_u_pctrlu_wb_reg_wr(a_wb_reg_wr), .o_u_pctrlu_wb_mem_to_reg(a_wb_m2r),
    .o_u_pctrlu_mult_busy(a_busy), .o_u_pctrlu_mult_done(a_done)
  );

  u_pctrlu #(.MULT_LAT(1), .MEM_STAGES(3), .ALU_CTR_W(4)) u_b (
    .i_u_pctrlu_clk(clk), .i_u_pctrlu_rst_n(rst_n),
    .i_u_pctrlu_op(op), .i_u_pctrlu_funct(funct), .i_u_pctrlu_valid(valid),
    .i_u_pctrlu_hazard_stall(hz), .i_u_pctrlu_flush_id(fl),
    .o_u_pctrlu_stall(b_stall), .o_u_pctrlu_id_pc_src(b_pc_src),
    .o_u_pctrlu_id_ext_op(b_ext_op), .o_u_pctrlu_id_jmp(b_jmp),
    .o_u_pctrlu_id_branch(b_branch), .o_u_pctrlu_ex_valid(b_ex_valid),
    .o_u_pctrlu_ex_alu_src(b_alu_src), .o_u_pctrlu_ex_mult_en(b_mult_en),
    .o_u_pctrlu_ex_data_sel(b_data_sel), .o_u_pctrlu_ex_alu_ctr(b_alu_ctr),
    .o_u_pctrlu_ex_reg_dst(b_reg_dst), .o_u_pctrlu_ex_mf(b_mf),
    .o_u_pctrlu_mem_valid(b_mem_valid), .o_u_pctrlu_mem_wr(b_mem_wr),
    .o_u_pctrlu_mem_word(b_mem_word), .o_u_pctrlu_wb_valid(b_wb_valid),
    .o_u_pctrlu_wb_reg_wr(b_wb_reg_wr), .o_u_pctrlu_wb_mem_to_reg(b_wb_m2r),
    .o_u_pctrlu_mult_busy(b_busy), .o_u_pctrlu_mult_done(b_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [5:0] o, input logic [5:0] f,
                       input logic v, input logic h, input logic x);
    op = o; funct = f; valid = v; hz = h; fl = x;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    drive(6'h00, 6'h00, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ex_valid", 32'(a_ex_valid), 0);
    chk("rst_state", 32'(u_a.u_multseq.state_q), 32'(IDLE));
    rst_n = 1'b1;

    // MULT enters EX, then reset mid-multiply
    drive(OP_RTYPE, FN_MULT, 1'b1, 1'b0, 1'b0);
    tick();
    chk("pre_rst_busy", 32'(a_busy), 1);
    chk("pre_rst_b_done", 32'(b_done), 1);
    drive(6'h00, 6'h00, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst_ex_valid", 32'(a_ex_valid), 0);
    chk("midrst_mult_en", 32'(a_mult_en), 0);
    chk("midrst_busy", 32'(a_busy), 0);
    chk("midrst_stall", 32'(a_stall), 0);
    chk("midrst_state", 32'(u_a.u_multseq.state_q), 32'(IDLE));
    chk("midrst_b_done", 32'(b_done), 0);
    rst_n = 1'b1;

    // ADD: EX +1, MEM +2, WB +3 (a) / +5 (b)
    drive(OP_RTYPE, FN_ADD, 1'b1, 1'b0, 1'b0);
    #1;
    chk("add_id_stall", 32'(a_stall), 0);
    tick();
    chk("add_ex_valid", 32'(a_ex_valid), 1);
    chk("add_ex_alu", 32'(a_alu_ctr), 32'(ALU_ADD));
    chk("add_ex_regdst", 32'(a_reg_dst), 32'(RD_RD));
    drive(6'h00, 6'h00, 1'b0, 1'b0, 1'b0);
    tick();
    chk("add_mem_valid", 32'(a_mem_valid), 1);
    chk("add_bubble_ex", 32'(a_ex_valid), 0);
    tick();
    chk("add_wb_valid", 32'(a_wb_valid), 1);
    chk("add_wb_regwr", 32'(a_wb_reg_wr), 1);
    chk("add_b_wb_early", 32'(b_wb_valid), 0);
    tick();
    tick();
    chk("add_b_wb_valid", 32'(b_wb_valid), 1);
    chk("add_b_wb_regwr", 32'(b_wb_reg_wr), 1);
    chk("add_a_wb_gone", 32'(a_wb_valid), 0);

    // LW then SW
    drive(OP_LW, 6'h00, 1'b1, 1'b0, 1'b0);
    tick();
    chk("lw_ex_alusrc", 32'(a_alu_src), 1);
    drive(OP_SW, 6'h00, 1'b1, 1'b0, 1'b0);
    tick();
    chk("lw_mem_valid", 32'(a_mem_valid), 1);
    chk("lw_mem_wr", 32'(a_mem_wr), 0);
    chk("lw_mem_word", 32'(a_mem_word), 1);
    drive(6'h00, 6'h00, 1'b0, 1'b0, 1'b0);
    tick();
    chk("sw_mem_wr", 32'(a_mem_wr), 1);
    chk("lw_wb_m2r", 32'(a_wb_m2r), 1);
    chk("lw_wb_regwr", 32'(a_wb_reg_wr), 1);
    tick();
    chk("sw_wb_valid", 32'(a_wb_valid), 1);
    chk("sw_wb_regwr", 32'(a_wb_reg_wr), 0);

    // MULT followed by ADD
    drive(OP_RTYPE, FN_MULT, 1'b1, 1'b0, 1'b0);
    #1;
    chk("mul_pre_stall", 32'(a_stall), 0);
    tick();
    drive(OP_RTYPE, FN_ADD, 1'b1, 1'b0, 1'b0);
    #1;
    chk("mul_c1_stall", 32'(a_stall), 1);
    chk("mul_c1_busy", 32'(a_busy), 1);
    chk("mul_c1_ex_mult", 32'(a_mult_en), 1);
    chk("mul_b_done", 32'(b_done), 1);
    chk("mul_b_stall", 32'(b_stall), 0);
    chk("mul_b_busy", 32'(b_busy), 0);
    for (int i = 2; i <= 3; i++) begin
      tick();
      chk("mul_hold_stall", 32'(a_stall), 1);
      chk("mul_hold_busy", 32'(a_busy), 1);
      chk("mul_hold_mem_bubble", 32'(a_mem_valid), 0);
      chk("mul_hold_done", 32'(a_done), 0);
    end
    chk("mul_b_done_once", 32'(b_done), 0);
    tick();
    chk("mul_c4_stall", 32'(a_stall), 0);
    chk("mul_c4_busy", 32'(a_busy), 0);
    chk("mul_c4_done", 32'(a_done), 1);
    chk("mul_c4_mem_bubble", 32'(a_mem_valid), 0);
    chk("mul_c4_ex_mult", 32'(a_mult_en), 1);
    tick();
    chk("mul_add_ex_valid", 32'(a_ex_valid), 1);
    chk("mul_add_ex_mult", 32'(a_mult_en), 0);
    chk("mul_add_ex_alu", 32'(a_alu_ctr), 32'(ALU_ADD));
    chk("mul_add_done", 32'(a_done), 0);
    chk("mul_to_mem", 32'(a_mem_valid), 1);

    // MULT immediately followed by MFHI
    drive(OP_RTYPE, FN_MULT, 1'b1, 1'b0, 1'b0);
    tick();
    drive(OP_RTYPE, FN_MFHI, 1'b1, 1'b0, 1'b0);
    #1;
    chk("mf_c1_stall", 32'(a_stall), 1);
    tick();
    tick();
    tick();
    chk("mf_last_done", 32'(a_done), 1);
    chk("mf_last_stall", 32'(a_stall), 0);
    tick();
    drive(OP_RTYPE, FN_MULT, 1'b1, 1'b0, 1'b0);
    #1;
    chk("mf_ex_valid", 32'(a_ex_valid), 1);
    chk("mf_ex_mf", 32'(a_mf), 32'(MF_HI));
    chk("mf_ex_regdst", 32'(a_reg_dst), 32'(RD_RD));
    chk("mf_no_stall", 32'(a_stall), 0);

    // Back-to-back multiplies (MULT kept in ID)
    tick();
    tick();
    tick();
    tick();
    chk("b2b_first_done", 32'(a_done), 1);
    tick();
    drive(6'h00, 6'h00, 1'b0, 1'b0, 1'b0);
    #1;
    chk("b2b_second_busy", 32'(a_busy), 1);
    chk("b2b_second_done", 32'(a_done), 0);
    chk("b2b_second_stall", 32'(a_stall), 1);
    tick();
    tick();
    chk("b2b_still_busy", 32'(a_busy), 1);
    tick();
    chk("b2b_second_last", 32'(a_done), 1);
    tick();
    chk("b2b_idle", 32'(u_a.u_multseq.state_q), 32'(IDLE));
    chk("b2b_ex_empty", 32'(a_ex_valid), 0);

    // flush_id kills the ID instruction
    drive(OP_RTYPE, FN_ADD, 1'b1, 1'b0, 1'b1);
    tick();
    chk("flush_ex_valid", 32'(a_ex_valid), 0);
    chk("flush_ex_alu", 32'(a_alu_ctr), 0);

    // BEQ under a two-cycle load-use stall
    drive(OP_BEQ, 6'h00, 1'b1, 1'b1, 1'b0);
    #1;
    chk("beq_st_stall", 32'(a_stall), 1);
    chk("beq_st_branch", 32'(a_branch), 0);
    chk("beq_st_pcsrc", 32'(a_pc_src), 0);
    tick();
    chk("beq_st_bubble1", 32'(a_ex_valid), 0);
    chk("beq_st_branch2", 32'(a_branch), 0);
    tick();
    chk("beq_st_bubble2", 32'(a_ex_valid), 0);
    drive(OP_BEQ, 6'h00, 1'b1, 1'b0, 1'b0);
    #1;
    chk("beq_branch", 32'(a_branch), 32'(BR_EQ));
    chk("beq_pcsrc", 32'(a_pc_src), 1);
    chk("beq_extop", 32'(a_ext_op), 1);
    chk("beq_stall", 32'(a_stall), 0);
    tick();
    drive(6'h00, 6'h00, 1'b0, 1'b0, 1'b0);
    #1;
    chk("beq_ex_valid", 32'(a_ex_valid), 1);
    chk("beq_ex_alu", 32'(a_alu_ctr), 32'(ALU_SUB));
    chk("beq_id_clear", 32'(a_branch), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
